// File: rtl/mini_src_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mini_src_pkg
//  Description : Shared types and constants for the Mini SRC RAM arbiter:
//                arbiter state encoding, bus-owner codes, default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package mini_src_pkg;

  localparam int DEF_AW = 9;   // 512-word RAM
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Winner select between CPU and DMA requests. CPU wins ties.
//                With MEM_ARB_FAIR_EN defined, a 4-bit starvation counter
//                forces a DMA grant after STARVE_MAX consecutive CPU grants
//                made while DMA was waiting.
//  Macro       : MEM_ARB_FAIR_EN (undefined: strict CPU priority, no state)
//  Ports       : clk, reset_n  - clock / async active-low reset (fair only)
//                i_idle        - arbiter is in IDLE, a grant happens now
//                i_cpu_req     - CPU request
//                i_dma_req     - DMA request
//                o_win         - OWN_NONE / OWN_CPU / OWN_DMA
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef MEM_ARB_FAIR_EN
module mem_arb_pick
  import mini_src_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_idle,
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  output logic [1:0] o_win
);

  logic [3:0] r_starve;
  logic       w_force_dma;

  assign w_force_dma = i_dma_req && (r_starve == 4'(STARVE_MAX));

  always_comb begin
    o_win = OWN_NONE;
    if (i_dma_req && (!i_cpu_req || w_force_dma)) begin
      o_win = OWN_DMA;
    end else if (i_cpu_req) begin
      o_win = OWN_CPU;
    end
  end

  // Counter only moves in IDLE, i.e. when a grant is actually being made.
  // It saturates naturally: reaching STARVE_MAX forces a DMA grant, which
  // clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (i_idle) begin
      if (!i_dma_req || (o_win == OWN_DMA)) begin
        r_starve <= '0;
      end else if (o_win == OWN_CPU) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule
`else
module mem_arb_pick
  import mini_src_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = OWN_NONE;
    if (i_cpu_req) begin
      o_win = OWN_CPU;
    end else if (i_dma_req) begin
      o_win = OWN_DMA;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single-port Mini SRC RAM between the CPU
//                datapath and a DMA/program-loader port. One word per
//                req/ack handshake: IDLE -> ACCESS -> [WAIT] -> RESP.
//  Macro       : MEM_ARB_FAIR_EN enables DMA anti-starvation in the picker.
//  Ports       : clk, reset_n                       clock, async low reset
//                cpu_req/we/addr/wdata, cpu_ack     CPU request port
//                dma_req/we/addr/wdata, dma_ack     DMA request port
//                rdata                              read data (valid on ack)
//                mem_en/we/addr/wdata, mem_rdata    RAM port
//                busy                               not IDLE
//                owner                              00 none, 01 CPU, 10 DMA
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mini_src_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);

  generate
    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
      $error("mem_port_arbiter: RD_LAT must be within 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_port_arbiter: STARVE_MAX must be within 1..15");
    end
  endgenerate

  arb_state_t    r_state, w_state_nxt;
  logic [2:0]    r_lat_cnt, w_lat_cnt_nxt;
  logic [1:0]    w_win;
  logic          w_take;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  logic          r_mem_en,    w_mem_en_d;
  logic          r_mem_we,    w_mem_we_d;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_d;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_d;
  logic          r_cpu_ack,   w_cpu_ack_d;
  logic          r_dma_ack,   w_dma_ack_d;
  logic [DW-1:0] r_rdata,     w_rdata_d;
  logic [1:0]    r_owner,     w_owner_d;

`ifdef MEM_ARB_FAIR_EN
  logic w_idle;
  assign w_idle = (r_state == ST_IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_idle    (w_idle),
    .i_cpu_req (cpu_req),
    .i_dma_req (dma_req),
    .o_win     (w_win)
  );
`else
  mem_arb_pick u_pick (
    .i_cpu_req (cpu_req),
    .i_dma_req (dma_req),
    .o_win     (w_win)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_win != OWN_NONE) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // r_mem_we holds the latched direction for the one ACCESS cycle.
        if (r_mem_we) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt   = ST_WAIT;
          w_lat_cnt_nxt = 3'(RD_LAT);
        end
      end
      ST_WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: computes the next value of every registered output so the
  // RAM strobes and acks come straight from flops.
  always_comb begin
    w_take      = (r_state == ST_IDLE) && (w_win != OWN_NONE);
    w_sel_we    = (w_win == OWN_DMA) ? dma_we    : cpu_we;
    w_sel_addr  = (w_win == OWN_DMA) ? dma_addr  : cpu_addr;
    w_sel_wdata = (w_win == OWN_DMA) ? dma_wdata : cpu_wdata;

    w_mem_en_d    = w_take;
    w_mem_we_d    = w_take && w_sel_we;
    w_mem_addr_d  = w_take ? w_sel_addr  : '0;
    w_mem_wdata_d = w_take ? w_sel_wdata : '0;

    w_owner_d = r_owner;
    if (w_take) begin
      w_owner_d = w_win;
    end else if (r_state == ST_RESP) begin
      w_owner_d = OWN_NONE;
    end

    w_cpu_ack_d = (w_state_nxt == ST_RESP) && (r_owner == OWN_CPU);
    w_dma_ack_d = (w_state_nxt == ST_RESP) && (r_owner == OWN_DMA);

    w_rdata_d = r_rdata;
    if ((r_state == ST_WAIT) && (r_lat_cnt == 3'd1)) begin
      w_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_rdata     <= '0;
      r_owner     <= OWN_NONE;
    end else begin
      r_mem_en    <= w_mem_en_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_cpu_ack   <= w_cpu_ack_d;
      r_dma_ack   <= w_dma_ack_d;
      r_rdata     <= w_rdata_d;
      r_owner     <= w_owner_d;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign rdata     = r_rdata;
  assign owner     = r_owner;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter. Two
//                instances: RD_LAT=1 (main) and RD_LAT=3 (latency case),
//                each with its own RAM model of matching read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // RD_LAT = 1 instance
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    owner;

  // RD_LAT = 3 instance
  logic          c3_cpu_req, c3_cpu_we, c3_cpu_ack;
  logic [AW-1:0] c3_cpu_addr;
  logic [DW-1:0] c3_cpu_wdata;
  logic          c3_dma_req, c3_dma_we, c3_dma_ack;
  logic [AW-1:0] c3_dma_addr;
  logic [DW-1:0] c3_dma_wdata;
  logic [DW-1:0] c3_rdata, c3_mem_wdata, c3_mem_rdata;
  logic          c3_mem_en, c3_mem_we, c3_busy;
  logic [AW-1:0] c3_mem_addr;
  logic [1:0]    c3_owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(c3_cpu_req), .cpu_we(c3_cpu_we), .cpu_addr(c3_cpu_addr), .cpu_wdata(c3_cpu_wdata), .cpu_ack(c3_cpu_ack),
    .dma_req(c3_dma_req), .dma_we(c3_dma_we), .dma_addr(c3_dma_addr), .dma_wdata(c3_dma_wdata), .dma_ack(c3_dma_ack),
    .rdata(c3_rdata), .mem_en(c3_mem_en), .mem_we(c3_mem_we), .mem_addr(c3_mem_addr), .mem_wdata(c3_mem_wdata),
    .mem_rdata(c3_mem_rdata), .busy(c3_busy), .owner(c3_owner)
  );

  // RAM models; read data is poisoned outside the valid latency slot.
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] ram1 [0:511];
  logic [DW-1:0] ram3 [0:511];
  logic [DW-1:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? ram1[mem_addr] : 32'hBAD0_0001;
    if (pre_en) ram1[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram1[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    p3_0 <= (c3_mem_en && !c3_mem_we) ? ram3[c3_mem_addr] : 32'hBAD0_0003;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    if (pre_en) ram3[pre_addr] <= pre_data;
    else if (c3_mem_en && c3_mem_we) ram3[c3_mem_addr] <= c3_mem_wdata;
  end
  assign c3_mem_rdata = p3_2;

  // Per-cycle capture buffers (index = cycles after the request cycle)
  logic       lg_en   [1:12];
  logic [1:0] lg_own  [1:12];
  logic       lg_cack [1:12];
  logic       lg_dack [1:12];
  logic       lg_busy [1:12];
  logic [31:0] lg_rd  [1:12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    step();
    pre_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    c3_cpu_req = 0; c3_cpu_we = 0; c3_cpu_addr = '0; c3_cpu_wdata = '0;
    c3_dma_req = 0; c3_dma_we = 0; c3_dma_addr = '0; c3_dma_wdata = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({mem_en, mem_we, cpu_ack, dma_ack, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, cpu_ack, dma_ack, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata, owner} !== '0) begin
      errors++; $display("FAIL reset_data: got addr %h wdata %h rdata %h owner %b want all 0", mem_addr, mem_wdata, rdata, owner);
    end
    checks++;
    if ({c3_mem_en, c3_busy, c3_cpu_ack, c3_owner, c3_rdata} !== '0) begin
      errors++; $display("FAIL reset_dut3: got en %b busy %b ack %b owner %b rdata %h want 0", c3_mem_en, c3_busy, c3_cpu_ack, c3_owner, c3_rdata);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    step(); // r+1
    checks++;
    if ({mem_en, mem_we, mem_addr, owner, busy} !== {1'b1, 1'b0, 9'h010, 2'b01, 1'b1}) begin
      errors++; $display("FAIL cpu_rd_access: got en %b we %b addr %h owner %b busy %b want 1 0 010 01 1", mem_en, mem_we, mem_addr, owner, busy);
    end
    step(); // r+2
    checks++;
    if ({mem_en, cpu_ack} !== 2'b00) begin
      errors++; $display("FAIL cpu_rd_wait: got en %b ack %b want 0 0", mem_en, cpu_ack);
    end
    step(); // r+3
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b10) begin
      errors++; $display("FAIL cpu_rd_ack: got cpu_ack %b dma_ack %b want 1 0", cpu_ack, dma_ack);
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cpu_rd_data: got %h want deadbeef", rdata);
    end
    cpu_req = 0;
    step(); // r+4
    checks++;
    if ({cpu_ack, busy, owner} !== 4'b0) begin
      errors++; $display("FAIL cpu_rd_idle: got ack %b busy %b owner %b want 0 0 00", cpu_ack, busy, owner);
    end
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 9'h1FF; dma_wdata = 32'h12345678;
    step(); // r+1
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, owner} !== {1'b1, 1'b1, 9'h1FF, 32'h12345678, 2'b10}) begin
      errors++; $display("FAIL dma_wr_access: got en %b we %b addr %h wdata %h owner %b want 1 1 1ff 12345678 10", mem_en, mem_we, mem_addr, mem_wdata, owner);
    end
    step(); // r+2
    checks++;
    if ({dma_ack, cpu_ack, mem_en} !== 3'b100) begin
      errors++; $display("FAIL dma_wr_ack: got dma_ack %b cpu_ack %b en %b want 1 0 0", dma_ack, cpu_ack, mem_en);
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dma_wr_rdata_hold: got %h want deadbeef", rdata);
    end
    dma_req = 0; dma_we = 0;
    step();
    // CPU read-back of the written word
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    step(); step(); step(); // r+3
    checks++;
    if ({cpu_ack, rdata} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL dma_wr_readback: got ack %b rdata %h want 1 12345678", cpu_ack, rdata);
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_tie();
    int n_en;
    int n_cack;
    int n_dack;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    dma_req = 1; dma_we = 0; dma_addr = 9'h1FF;
    for (int k = 1; k <= 12; k++) begin
      step();
      lg_en[k] = mem_en; lg_own[k] = owner; lg_cack[k] = cpu_ack;
      lg_dack[k] = dma_ack; lg_rd[k] = rdata;
      if (cpu_ack) cpu_req = 0;
      if (dma_ack) dma_req = 0;
    end
    n_en = 0; n_cack = 0; n_dack = 0;
    for (int k = 1; k <= 12; k++) begin
      n_en   += int'(lg_en[k]);
      n_cack += int'(lg_cack[k]);
      n_dack += int'(lg_dack[k]);
    end
    checks++;
    if ({lg_en[1], lg_own[1], lg_en[5], lg_own[5]} !== {1'b1, 2'b01, 1'b1, 2'b10}) begin
      errors++; $display("FAIL tie_order: got c1 en %b own %b c5 en %b own %b want 1 01 1 10", lg_en[1], lg_own[1], lg_en[5], lg_own[5]);
    end
    checks++;
    if (n_en !== 2) begin
      errors++; $display("FAIL tie_mem_en_count: got %0d want 2", n_en);
    end
    checks++;
    if ({n_cack, n_dack, lg_cack[3], lg_dack[7]} !== {32'd1, 32'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL tie_acks: got ncack %0d ndack %0d c3 %b d7 %b want 1 1 1 1", n_cack, n_dack, lg_cack[3], lg_dack[7]);
    end
    checks++;
    if ({lg_rd[3], lg_rd[7]} !== {32'hDEADBEEF, 32'h12345678}) begin
      errors++; $display("FAIL tie_rdata: got %h %h want deadbeef 12345678", lg_rd[3], lg_rd[7]);
    end
  endtask

  task automatic test_starvation();
    int cpu_grants;
    int dma_grants;
    int cpu_before;
    int first_cpu;
    int second_cpu;
    int wait_cnt;
    bit got;
    cpu_grants = 0; dma_grants = 0; cpu_before = -1; first_cpu = 0; second_cpu = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h020; cpu_wdata = 32'h0000_0A5A;
    dma_req = 1; dma_we = 0; dma_addr = 9'h010;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (mem_en && owner == 2'b01) begin
        cpu_grants++;
        if (cpu_grants == 1) first_cpu = k;
        if (cpu_grants == 2) second_cpu = k;
      end
      if (mem_en && owner == 2'b10) begin
        if (dma_grants == 0) cpu_before = cpu_grants;
        dma_grants++;
      end
      if (dma_ack) dma_req = 0;
    end
    checks++;
    if (second_cpu - first_cpu !== 3) begin
      errors++; $display("FAIL b2b_write_interval: got %0d want 3", second_cpu - first_cpu);
    end
`ifdef MEM_ARB_FAIR_EN
    checks++;
    if ({cpu_before, dma_grants} !== {32'd4, 32'd1}) begin
      errors++; $display("FAIL fair_dma_grant: got cpu_before %0d dma_grants %0d want 4 1", cpu_before, dma_grants);
    end
`else
    checks++;
    if ({dma_grants, cpu_grants} !== {32'd0, 32'd14}) begin
      errors++; $display("FAIL strict_starve: got dma_grants %0d cpu_grants %0d want 0 14", dma_grants, cpu_grants);
    end
`endif
    // Let the CPU finish its current access, then stop it.
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (cpu_ack) got = 1;
    end
    cpu_req = 0; cpu_we = 0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL starve_cpu_ack_timeout: got none want ack within 8 cycles");
    end
    if (dma_req) begin
      got = 0; wait_cnt = 0;
      for (int k = 1; k <= 12 && !got; k++) begin
        step();
        if (dma_ack) begin got = 1; wait_cnt = k; end
      end
      dma_req = 0;
      checks++;
      if ({got, wait_cnt, rdata} !== {1'b1, 32'd4, 32'hDEADBEEF}) begin
        errors++; $display("FAIL starve_dma_after_cpu: got seen %b delay %0d rdata %h want 1 4 deadbeef", got, wait_cnt, rdata);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    bit stray;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
    step(); step(); // r+2: WAIT
    checks++;
    if ({busy, owner} !== 3'b1_01) begin
      errors++; $display("FAIL rst_mid_pre: got busy %b owner %b want 1 01", busy, owner);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, owner, mem_en, mem_we, cpu_ack, dma_ack, rdata} !== '0) begin
      errors++; $display("FAIL rst_mid_async: got busy %b owner %b en %b we %b acks %b%b rdata %h want 0", busy, owner, mem_en, mem_we, cpu_ack, dma_ack, rdata);
    end
    cpu_req = 0;
    step(); step();
    #2 reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (cpu_ack || dma_ack || busy) stray = 1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_ack: got activity %b want 0", stray);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    step(); step(); step();
    checks++;
    if ({cpu_ack, rdata} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL rst_mid_recover: got ack %b rdata %h want 1 12345678", cpu_ack, rdata);
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_rd_lat3();
    bit busy_ok;
    bit en_ok;
    bit ack_ok;
    c3_cpu_req = 1; c3_cpu_we = 0; c3_cpu_addr = 9'h0AB;
    for (int k = 1; k <= 7; k++) begin
      step();
      lg_en[k] = c3_mem_en; lg_cack[k] = c3_cpu_ack;
      lg_busy[k] = c3_busy; lg_rd[k] = c3_rdata;
      if (c3_cpu_ack) c3_cpu_req = 0;
    end
    busy_ok = 1; en_ok = 1; ack_ok = 1;
    for (int k = 1; k <= 7; k++) begin
      if (lg_busy[k] !== (k <= 5)) busy_ok = 0;
      if (lg_en[k] !== (k == 1)) en_ok = 0;
      if (lg_cack[k] !== (k == 5)) ack_ok = 0;
    end
    checks++;
    if (ack_ok !== 1'b1) begin
      errors++; $display("FAIL lat3_ack_cycle: got acks %b%b%b%b%b%b%b want 0000100", lg_cack[1], lg_cack[2], lg_cack[3], lg_cack[4], lg_cack[5], lg_cack[6], lg_cack[7]);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++; $display("FAIL lat3_busy: got busy %b%b%b%b%b%b%b want 1111100", lg_busy[1], lg_busy[2], lg_busy[3], lg_busy[4], lg_busy[5], lg_busy[6], lg_busy[7]);
    end
    checks++;
    if (en_ok !== 1'b1) begin
      errors++; $display("FAIL lat3_mem_en: got en %b%b%b%b%b%b%b want 1000000", lg_en[1], lg_en[2], lg_en[3], lg_en[4], lg_en[5], lg_en[6], lg_en[7]);
    end
    checks++;
    if ({lg_rd[4], lg_rd[5]} !== {32'h0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL lat3_rdata: got c4 %h c5 %h want 00000000 cafef00d", lg_rd[4], lg_rd[5]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload(9'h010, 32'hDEADBEEF);
    preload(9'h0AB, 32'hCAFEF00D);
    step();
    test_cpu_read();
    test_dma_write();
    test_tie();
    test_starvation();
    test_reset_mid();
    test_rd_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port Mini SRC RAM between the CPU datapath (MAR/MDR path sequenced by the control unit) and an external DMA/program-loader port. Each requester issues one word read or write per request/ack handshake; the arbiter registers the winning request, drives the RAM for one cycle, waits out the read latency and returns data with a one-cycle ack. CPU has priority, with an optional anti-starvation mechanism for the DMA port.

## Interface
- AW, 9, RAM word-address width (512 words)
- DW, 32, data width
- RD_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata (legal 1..7)
- STARVE_MAX, 4, consecutive CPU grants tolerated while dma_req pending (used only with MEM_ARB_FAIR_EN, legal 1..15)

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req / dma_we / dma_addr / dma_wdata / dma_ack  same as CPU set, DMA port
- rdata  out  DW  read data, valid when the reader's ack is high
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (only with mem_en)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data
- busy  out  1  high in every state except IDLE
- owner  out  2  00 none, 01 CPU, 10 DMA

## Operation
- Reset: state IDLE, all outputs 0, rdata 0, starvation counter 0, latched request fields 0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req, pick winner, latch we/addr/wdata and owner, go ACCESS; else stay.
- Pick: cpu_req wins any tie; DMA granted when cpu_req low (see Configuration for starvation override).
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latches. Write -> RESP; read -> WAIT with latency counter loaded RD_LAT.
- WAIT: decrement counter each cycle; on cycle counter==1 capture mem_rdata into rdata, go RESP.
- RESP: ack of owner = 1 for exactly this cycle; go IDLE, owner cleared on exit.
- mem_en, mem_we, acks registered (glitch-free); mem_* hold 0 outside ACCESS.
- Requester drops req on the edge that samples ack; arbiter re-samples req only in IDLE, so no double issue.
- req withdrawn before ack: protocol violation; transaction completes and ack still pulses.
- Write has no rdata update; rdata holds last read value.
- Reset mid-transaction: asynchronous return to IDLE, mem_en/mem_we drop immediately, no ack issued, RAM write in progress may be lost.

## Timing
- req sampled high in IDLE at cycle r: ACCESS r+1, write ack r+2, read ack r+2+RD_LAT (r+3 default).
- Back-to-back: next grant earliest cycle after RESP; min issue interval 3 cycles write, 3+RD_LAT read.
- busy high from r+1 through ack cycle inclusive.

## Configuration
- MEM_ARB_FAIR_EN defined: 4-bit starvation counter increments on each CPU grant made while dma_req high; clears on DMA grant or whenever dma_req low in IDLE. When counter == STARVE_MAX in IDLE with dma_req high, DMA wins even if cpu_req high.
- Undefined: strict CPU priority, counter not instantiated; DMA may starve indefinitely.

## Structure
- mini_src_pkg: arbiter state enum (IDLE/ACCESS/WAIT/RESP), owner encodings OWN_NONE/OWN_CPU/OWN_DMA, default AW/DW constants.
- One sub-module: mem_arb_pick (combinational winner select plus, under MEM_ARB_FAIR_EN, the starvation counter register).

## Test plan
- Reset then CPU read addr 0x010, RAM holds 0xDEADBEEF, RD_LAT=1 -> mem_en at r+1, cpu_ack with rdata=0xDEADBEEF at r+3, dma_ack stays 0.
- DMA write addr 0x1FF data 0x12345678 -> mem_en=mem_we=1 at r+1, dma_ack at r+2; subsequent CPU read of 0x1FF returns 0x12345678.
- cpu_req and dma_req raised same cycle -> CPU served first (owner=01), DMA served immediately after (owner=10), no overlap of mem_en.
- With MEM_ARB_FAIR_EN, STARVE_MAX=4, CPU requests continuously and dma_req held -> DMA granted after exactly 4 CPU grants; without macro DMA never granted until cpu_req drops.
- reset_n pulsed low during WAIT of a read -> mem_en/acks 0 immediately, state IDLE, no ack after release; next request completes normally.
- RD_LAT=3 read -> cpu_ack at r+5 with correct data, busy high r+1..r+5.
